// File: rtl/de_pipe_pkg.sv
// Shared types for the decode/execute pipeline stages.
//   skid_st_e      : occupancy state of a skid-buffered stage register.
//   de_ex_payload_t: decoded bundle handed from decode to execute. Instantiate
//                    de_stage_skid with WIDTH = $bits(de_ex_payload_t).
package de_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_st_e;

  typedef struct packed {
    logic [2:0]  immsrc;
    logic [11:0] control;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } de_ex_payload_t;

endpackage

// File: rtl/de_sat_cnt.sv
// Saturating up-counter.
//   clk_i  : clock
//   clr_ni : synchronous clear, active low
//   inc_i  : count by one this cycle (ignored once all ones)
//   cnt_o  : current count
module de_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/de_stage_skid.sv
// Decode-to-execute stage register with valid/ready handshake and a one-entry
// skid buffer. Sustains one transfer per cycle; in_ready_o is a decode of the
// state register only, so there is no combinational out_ready_i -> in_ready_o
// path.
//   clk_i       : clock
//   rst_ni      : synchronous reset, active low
//   flush_i     : drop all held entries (data registers keep their contents)
//   in_valid_i  / in_ready_o  / in_data_i  : upstream handshake and payload
//   out_valid_o / out_ready_i / out_data_o : downstream handshake and payload
//   stall_cnt_o : saturating count of cycles with out_valid_o & !out_ready_i
module de_stage_skid
  import de_pipe_pkg::*;
#(
  parameter int unsigned           WIDTH   = 32,
  parameter logic [WIDTH-1:0]      RST_VAL = '0,
  parameter int unsigned           CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  skid_st_e         state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, drain;

  assign accept = in_valid_i & in_ready_o;
  assign drain  = out_valid_o & out_ready_i;

  // State and data registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and data
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = in_data_i;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = ST_FULL;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush kills occupancy only; the payload registers are left untouched.
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Outputs
  always_comb begin
    out_valid_o = (state_q != ST_EMPTY);
    in_ready_o  = (state_q != ST_FULL);
  end

  assign out_data_o = main_q;

  de_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_ni),
    .inc_i  (out_valid_o & ~out_ready_i),
    .cnt_o  (stall_cnt_o)
  );

endmodule

// File: doc/de_stage_skid.md
# de_stage_skid

Parametrised decode-to-execute pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. It replaces the per-field enable-gated stage registers: the whole decoded bundle (immsrc, control, operands) is packed into one payload bus. Full throughput (1 transfer/cycle) and no combinational path from `out_ready` to `in_ready`.

## Interface

- `WIDTH`, 32, payload width in bits (≥1).
- `RST_VAL`, '0, payload value loaded into both data registers on reset.
- `CNT_W`, 16, stall counter width (≥1).

- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-low: sampled on rising `clk`, resets when 0.
- `flush`  input  1  discard all held entries (branch/exception kill).
- `in_valid`  input  1  upstream (decode) payload valid.
- `in_ready`  output  1  stage can accept a payload this cycle.
- `in_data`  input  WIDTH  upstream payload.
- `out_valid`  output  1  payload presented to execute.
- `out_ready`  input  1  execute accepts payload this cycle.
- `out_data`  output  WIDTH  payload to execute.
- `stall_cnt`  output  CNT_W  cycles with `out_valid & !out_ready`, saturating.

## Operation

- Two data registers: `main` (drives `out_data`) and `skid`. State machine: ST_EMPTY, ST_ONE (main valid), ST_FULL (main + skid valid).
- `out_valid` = state ≠ ST_EMPTY; `in_ready` = state ≠ ST_FULL. Both are pure decodes of the state register.
- Accept = `in_valid & in_ready`; drain = `out_valid & out_ready`.
- ST_EMPTY: accept → main ← in_data, ST_ONE; otherwise stay.
- ST_ONE: accept & drain → main ← in_data, stay. Accept & !drain → skid ← in_data, ST_FULL. !accept & drain → ST_EMPTY. Neither → hold.
- ST_FULL: drain → main ← skid, ST_ONE. No accept is possible (`in_ready` = 0).
- Ordering is strictly FIFO; no payload is duplicated or dropped except by flush.
- Priority: reset > flush > normal operation.
- Flush: next state ST_EMPTY regardless of current state and handshakes. A payload accepted in the flush cycle is discarded. A drain in the flush cycle still counts as completed for the consumer. Data registers hold their values.
- `stall_cnt`: +1 each cycle with `out_valid & !out_ready`, including the flush cycle. Saturates at 2^CNT_W−1. Cleared only by reset; flush does not clear it.
- Reset (rst = 0 at edge): state ST_EMPTY, main = skid = RST_VAL, stall_cnt = 0. After the reset edge: `out_valid` = 0, `in_ready` = 1, `out_data` = RST_VAL. Reset mid-transfer discards all entries.

## Timing

- Latency: a payload accepted at edge N is visible on `out_data` with `out_valid` = 1 from edge N+1 when the stage was empty or drained that cycle. Otherwise it waits behind the older entry.
- Throughput: 1 payload/cycle sustained when `out_ready` is held 1.
- `in_ready` falls the cycle after an accept without a drain from ST_ONE. It rises the cycle after the drain from ST_FULL.
- Flush takes effect at the edge where it is sampled. `out_valid` = 0 the following cycle.
- All outputs are registered or decoded from registers only; no input-to-output combinational path.

## Structure

- Shared package `de_pipe_pkg`: `typedef enum logic [1:0] {ST_EMPTY=2'b00, ST_ONE=2'b01, ST_FULL=2'b10} skid_st_e`. Each stage's payload packed-struct typedefs also live there, so callers set `WIDTH = $bits(struct)`.
- One natural sub-module: `de_sat_cnt` (parametrised CNT_W saturating counter with `inc` and synchronous active-low clear). Instantiated once for `stall_cnt`.
- Unreachable encoding 2'b11 recovers to ST_EMPTY.

## Test plan

- Reset with WIDTH=8, RST_VAL=8'hA5: hold rst = 0 for 2 edges → `out_valid` = 0, `in_ready` = 1, `out_data` = 8'hA5, `stall_cnt` = 0.
- Streaming: `out_ready` = 1, push 0x01..0x10 back-to-back → outputs 0x01..0x10 in order, 1-cycle latency, `in_ready` never drops.
- Backpressure: push 0x11, 0x22, 0x33 with `out_ready` = 0 → 0x11 on out, 0x22 in skid, `in_ready` = 0, 0x33 not accepted. Raise `out_ready` → 0x11, 0x22, then 0x33 delivered; `stall_cnt` equals the number of stalled cycles.
- Flush in ST_FULL with a simultaneous `in_valid` → next cycle `out_valid` = 0, `in_ready` = 1, nothing delivered afterwards until a new push.
- Saturation with CNT_W=3: hold `out_valid` = 1, `out_ready` = 0 for 10 cycles → `stall_cnt` stops at 7; a flush leaves it at 7; reset returns it to 0.
- Reset asserted while ST_FULL with `in_valid` = 1 → after the edge, state empty and outputs at reset values; first post-reset push appears unaltered one cycle later.
